multicycle_ctrl: RTL and testbench

Control FSM that sequences the RV32I subset (lw, sw, R-type, I-type ALU, beq, jal, jalr) on a multicycle variant of our datapath. The datapath shares one memory for instructions and data and has IR, OldPC, A/B, ALUOut and Data registers.
The block replaces the single-cycle maindec/controller pair. It drives every datapath select and enable, and stalls on a memory-ready handshake.

---
 rtl/multicycle_pkg.sv | 77 +++++++
 rtl/multicycle_ctrl_aludec.sv | 44 ++++
 rtl/multicycle_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle RV32I control FSM: states, datapath
// select codes, ALU operation codes and the opcodes the FSM recognises.
package multicycle_pkg;

    // FSM states; FETCH must stay at zero so a cleared register means FETCH.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_JALRLINK = 4'd12,
        S_ILLEGAL  = 4'd13
    } state_e;

    // ALUOp: how the ALU decoder chooses the operation
    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    // ResultSrc
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // ALUSrcA
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;

    // ALUSrcB
    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // ImmSrc
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // ALUControl operation codes understood by the alu
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Opcodes
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // Immediate format selected purely from the opcode
    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        logic [1:0] imm;
        case (op)
            OP_STORE:  imm = IMM_S;
            OP_BRANCH: imm = IMM_B;
            OP_JAL:    imm = IMM_J;
            default:   imm = IMM_I;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_aludec.sv
// ALU decoder: turns ALUOp plus the instruction function bits into an ALU
// operation. Subtract for R-type only when funct7[5] is set on an R-type op.
module aludec
    import multicycle_pkg::*;
#(
    parameter int ALUCTL_W = 3
) (
    input  logic                opb5,
    input  logic [2:0]          funct3,
    input  logic                funct7b5,
    input  logic [1:0]          ALUOp,
    output logic [ALUCTL_W-1:0] ALUControl
);

    logic [2:0] alu_ctl_s;

    // Select the ALU operation from ALUOp and, for ALUOP_FUNC, from funct3
    always_comb begin
        alu_ctl_s = ALU_ADD;
        case (ALUOp)
            ALUOP_ADD: alu_ctl_s = ALU_ADD;
            ALUOP_SUB: alu_ctl_s = ALU_SUB;
            ALUOP_FUNC: begin
                case (funct3)
                    3'b000: begin
                        if (opb5 && funct7b5) begin
                            alu_ctl_s = ALU_SUB;
                        end else begin
                            alu_ctl_s = ALU_ADD;
                        end
                    end
                    3'b010:  alu_ctl_s = ALU_SLT;
                    3'b110:  alu_ctl_s = ALU_OR;
                    3'b111:  alu_ctl_s = ALU_AND;
                    default: alu_ctl_s = ALU_ADD;
                endcase
            end
            default: alu_ctl_s = ALU_ADD;
        endcase
    end

    assign ALUControl = ALUCTL_W'(alu_ctl_s);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the RV32I subset (lw, sw, R/I ALU, beq, jal,
// jalr). Outputs decode from the state register; only PCWrite looks at Zero
// (BEQ) and PCWrite/IRWrite look at mem_ready (FETCH). Reset aborts any
// instruction in flight and masks all write enables while it is held.
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter int ALUCTL_W = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [6:0]          op,
    input  logic [2:0]          funct3,
    input  logic                funct7b5,
    input  logic                Zero,
    input  logic                mem_ready,
    output logic                PCWrite,
    output logic                AdrSrc,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic [1:0]          ResultSrc,
    output logic [1:0]          ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [ALUCTL_W-1:0] ALUControl,
    output logic [1:0]          ImmSrc,
    output logic                RegWrite,
    output logic                illegal,
    output logic [3:0]          state_o
);

    state_e     state_q;
    state_e     state_d;
    logic       pc_write_s;
    logic       ir_write_s;
    logic       mem_write_s;
    logic       reg_write_s;
    logic [1:0] alu_op_s;

    // Next-state logic; mem_ready is only consulted in the memory states
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                case (op)
                    OP_LOAD,
                    OP_STORE:  state_d = S_MEMADR;
                    OP_RTYPE:  state_d = S_EXECUTER;
                    OP_ITYPE:  state_d = S_EXECUTEI;
                    OP_BRANCH: state_d = S_BEQ;
                    OP_JAL:    state_d = S_JAL;
                    OP_JALR:   state_d = S_JALR;
                    default:   state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                if (op[5]) begin
                    state_d = S_MEMWRITE;
                end else begin
                    state_d = S_MEMREAD;
                end
            end
            S_MEMREAD: begin
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else begin
                    state_d = S_MEMREAD;
                end
            end
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_MEMWRITE;
                end
            end
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_JALR:     state_d = S_JALRLINK;
            S_JALRLINK: state_d = S_ALUWB;
            S_ILLEGAL:  state_d = S_ILLEGAL;
            default:    state_d = S_ILLEGAL;
        endcase
    end

    // State register with synchronous reset back to FETCH
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath controls decoded from the current state
    always_comb begin
        pc_write_s  = 1'b0;
        ir_write_s  = 1'b0;
        mem_write_s = 1'b0;
        reg_write_s = 1'b0;
        AdrSrc      = 1'b0;
        ResultSrc   = RES_ALUOUT;
        ALUSrcA     = SRCA_PC;
        ALUSrcB     = SRCB_B;
        alu_op_s    = ALUOP_ADD;
        illegal     = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALURESULT;
                pc_write_s = mem_ready;
                ir_write_s = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_A;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc   = RES_DATA;
                reg_write_s = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc      = 1'b1;
                mem_write_s = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA  = SRCA_A;
                alu_op_s = ALUOP_FUNC;
            end
            S_EXECUTEI: begin
                ALUSrcA  = SRCA_A;
                ALUSrcB  = SRCB_IMM;
                alu_op_s = ALUOP_FUNC;
            end
            S_ALUWB: begin
                reg_write_s = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA    = SRCA_A;
                alu_op_s   = ALUOP_SUB;
                pc_write_s = Zero;
            end
            S_JAL: begin
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                pc_write_s = 1'b1;
            end
            S_JALR: begin
                ALUSrcA    = SRCA_A;
                ALUSrcB    = SRCB_IMM;
                ResultSrc  = RES_ALURESULT;
                pc_write_s = 1'b1;
            end
            S_JALRLINK: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
            end
            S_ILLEGAL: begin
                illegal = 1'b1;
            end
            default: begin
                illegal = 1'b0;
            end
        endcase
    end

    // Write enables are masked for as long as reset is held
    assign PCWrite  = pc_write_s  & ~reset;
    assign IRWrite  = ir_write_s  & ~reset;
    assign MemWrite = mem_write_s & ~reset;
    assign RegWrite = reg_write_s & ~reset;

    assign ImmSrc   = imm_src_of(op);
    assign state_o  = state_q;

    aludec #(
        .ALUCTL_W (ALUCTL_W)
    ) u_aludec (
        .opb5       (op[5]),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .ALUOp      (alu_op_s),
        .ALUControl (ALUControl)
    );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: a phase-route model predicts every output each
// cycle, and directed instruction runs add hand-computed expectations.
module tb_multicycle_ctrl;
    import multicycle_pkg::*;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       mem_ready;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] state_o;

    multicycle_ctrl #(.ALUCTL_W(3)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
        .ImmSrc(ImmSrc), .RegWrite(RegWrite), .illegal(illegal), .state_o(state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // Control table per phase:
    // [15] AdrSrc [14:13] ResultSrc [12:11] ALUSrcA [10:9] ALUSrcB [8:7] ALUOp
    // [6] RegWrite [5] MemWrite [4:3] PCWrite kind (0 off,1 on,2 Zero,3 mem_ready)
    // [2] IRWrite follows mem_ready [1] illegal [0] unused
    logic [15:0] tbl [0:15];
    initial begin
        for (int i = 0; i < 16; i++) tbl[i] = 16'h0000;
        tbl[S_FETCH]    = {1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0};
        tbl[S_DECODE]   = {1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
        tbl[S_MEMADR]   = {1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
        tbl[S_MEMREAD]  = {1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
        tbl[S_MEMWB]    = {1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
        tbl[S_MEMWRITE] = {1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0};
        tbl[S_EXECUTER] = {1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
        tbl[S_EXECUTEI] = {1'b0, 2'b00, 2'b10, 2'b01, 2'b10, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
        tbl[S_ALUWB]    = {1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
        tbl[S_BEQ]      = {1'b0, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0};
        tbl[S_JAL]      = {1'b0, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0};
        tbl[S_JALR]     = {1'b0, 2'b10, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0};
        tbl[S_JALRLINK] = {1'b0, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
        tbl[S_ILLEGAL]  = {1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0};
    end

    function automatic logic [2:0] exp_alu(input logic [1:0] aop, input logic b5,
                                           input logic [2:0] f3, input logic f7);
        if (aop == 2'b00) return 3'b000;
        if (aop == 2'b01) return 3'b001;
        case (f3)
            3'b000:  return (b5 && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [1:0] exp_imm(input logic [6:0] o);
        if (o == 7'b0100011) return 2'b01;
        if (o == 7'b1100011) return 2'b10;
        if (o == 7'b1101111) return 2'b11;
        return 2'b00;
    endfunction

    // Model: current phase plus the remaining phases of the instruction.
    state_e phase;
    state_e route[$];
    bit     model_valid = 1'b0;

    // Observation counters (only the monitor writes these)
    int cnt_pcw = 0, cnt_mw = 0, cnt_rw = 0, cnt_rw_data = 0, cnt_adr = 0;
    int cnt_ill = 0, cnt_pcw_rs10 = 0;
    logic [2:0] last_exec_alu = 3'b111;
    logic [2:0] last_beq_alu  = 3'b111;

    // Compare DUT against the model on the falling edge, then advance the model
    always @(negedge clk) begin
        logic [15:0] row;
        logic        e_pcw, e_irw, e_mw, e_rw;
        logic [20:0] e_vec, a_vec;
        if (model_valid) begin
            row   = tbl[phase];
            case (row[4:3])
                2'd0:    e_pcw = 1'b0;
                2'd1:    e_pcw = 1'b1;
                2'd2:    e_pcw = Zero;
                default: e_pcw = mem_ready;
            endcase
            e_irw = row[2] & mem_ready;
            e_mw  = row[5];
            e_rw  = row[6];
            if (reset) begin
                e_pcw = 1'b0; e_irw = 1'b0; e_mw = 1'b0; e_rw = 1'b0;
            end
            e_vec = {phase, e_pcw, row[15], e_mw, e_irw, row[14:13], row[12:11], row[10:9],
                     exp_alu(row[8:7], op[5], funct3, funct7b5), exp_imm(op), e_rw, row[1]};
            a_vec = {state_o, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                     ALUControl, ImmSrc, RegWrite, illegal};
            chk("cycle", {11'd0, a_vec}, {11'd0, e_vec});
            if (PCWrite) cnt_pcw++;
            if (PCWrite && ResultSrc == 2'b10) cnt_pcw_rs10++;
            if (MemWrite) cnt_mw++;
            if (RegWrite) cnt_rw++;
            if (RegWrite && ResultSrc == 2'b01) cnt_rw_data++;
            if (AdrSrc) cnt_adr++;
            if (illegal) cnt_ill++;
            if (phase == S_EXECUTER || phase == S_EXECUTEI) last_exec_alu = ALUControl;
            if (phase == S_BEQ) last_beq_alu = ALUControl;
        end
        if (reset) begin
            phase = S_FETCH;
            route.delete();
            model_valid = 1'b1;
        end else if (model_valid) begin
            if ((phase == S_FETCH || phase == S_MEMREAD || phase == S_MEMWRITE) && !mem_ready) begin
                phase = phase;
            end else if (phase == S_FETCH) begin
                route.delete();
                route.push_back(S_DECODE);
                case (op)
                    7'b0000011: begin route.push_back(S_MEMADR); route.push_back(S_MEMREAD); route.push_back(S_MEMWB); end
                    7'b0100011: begin route.push_back(S_MEMADR); route.push_back(S_MEMWRITE); end
                    7'b0110011: begin route.push_back(S_EXECUTER); route.push_back(S_ALUWB); end
                    7'b0010011: begin route.push_back(S_EXECUTEI); route.push_back(S_ALUWB); end
                    7'b1100011: route.push_back(S_BEQ);
                    7'b1101111: begin route.push_back(S_JAL); route.push_back(S_ALUWB); end
                    7'b1100111: begin route.push_back(S_JALR); route.push_back(S_JALRLINK); route.push_back(S_ALUWB); end
                    default:    route.push_back(S_ILLEGAL);
                endcase
                phase = route.pop_front();
            end else if (phase == S_ILLEGAL) begin
                phase = S_ILLEGAL;
            end else if (route.size() > 0) begin
                phase = route.pop_front();
            end else begin
                phase = S_FETCH;
            end
        end
    end

    task automatic cyc(input logic mr);
        mem_ready = mr;
        @(posedge clk);
        #1;
    endtask

    int b_pcw, b_mw, b_rw, b_rwd, b_adr, b_ill, b_rs10;

    // Run one instruction for n cycles; stall bit i holds mem_ready low in cycle i
    task automatic run(input string nm, input logic [6:0] o, input logic [2:0] f3,
                       input logic f7, input logic z, input int n,
                       input logic [31:0] stall, input logic [3:0] end_state);
        op = o; funct3 = f3; funct7b5 = f7; Zero = z;
        b_pcw = cnt_pcw; b_mw = cnt_mw; b_rw = cnt_rw; b_rwd = cnt_rw_data;
        b_adr = cnt_adr; b_ill = cnt_ill; b_rs10 = cnt_pcw_rs10;
        for (int i = 0; i < n; i++) cyc(~stall[i]);
        chk({nm, "_end_state"}, {28'd0, state_o}, {28'd0, end_state});
    endtask

    initial begin
        reset = 1'b1; mem_ready = 1'b1; op = 7'b0010011; funct3 = 3'b000;
        funct7b5 = 1'b0; Zero = 1'b0;
        // reset held two cycles
        @(posedge clk); #1;
        chk("rst_memwrite", {31'd0, MemWrite}, 32'd0);
        chk("rst_regwrite", {31'd0, RegWrite}, 32'd0);
        chk("rst_pcwrite", {31'd0, PCWrite}, 32'd0);
        @(posedge clk); #1;
        chk("rst_state", {28'd0, state_o}, 32'd0);
        chk("rst_irwrite", {31'd0, IRWrite}, 32'd0);
        reset = 1'b0;
        #3;
        chk("rel_pcwrite", {31'd0, PCWrite}, 32'd1);
        chk("rel_irwrite", {31'd0, IRWrite}, 32'd1);
        @(posedge clk); #1;
        cyc(1'b1); cyc(1'b1); cyc(1'b1);
        chk("addi_end_state", {28'd0, state_o}, 32'd0);

        // lw with two wait cycles in MEMREAD: 7 cycles
        run("lw", 7'b0000011, 3'b010, 1'b0, 1'b0, 7, 32'h18, 4'd0);
        chk("lw_regwrite_cnt", cnt_rw - b_rw, 32'd1);
        chk("lw_regwrite_data", cnt_rw_data - b_rwd, 32'd1);

        run("sw", 7'b0100011, 3'b010, 1'b0, 1'b0, 4, 32'h0, 4'd0);
        chk("sw_memwrite_cnt", cnt_mw - b_mw, 32'd1);
        chk("sw_adrsrc_cnt", cnt_adr - b_adr, 32'd1);
        chk("sw_regwrite_cnt", cnt_rw - b_rw, 32'd0);

        run("add", 7'b0110011, 3'b000, 1'b0, 1'b0, 4, 32'h0, 4'd0);
        chk("add_alu", {29'd0, last_exec_alu}, 32'd0);
        run("sub", 7'b0110011, 3'b000, 1'b1, 1'b0, 4, 32'h0, 4'd0);
        chk("sub_alu", {29'd0, last_exec_alu}, 32'd1);
        run("or", 7'b0110011, 3'b110, 1'b0, 1'b0, 4, 32'h0, 4'd0);
        chk("or_alu", {29'd0, last_exec_alu}, 32'd3);
        run("slti", 7'b0010011, 3'b010, 1'b0, 1'b0, 4, 32'h0, 4'd0);
        chk("slti_alu", {29'd0, last_exec_alu}, 32'd5);
        run("addi_b30", 7'b0010011, 3'b000, 1'b1, 1'b0, 4, 32'h0, 4'd0);
        chk("addi_b30_alu", {29'd0, last_exec_alu}, 32'd0);

        run("beq_taken", 7'b1100011, 3'b000, 1'b0, 1'b1, 3, 32'h0, 4'd0);
        chk("beq_taken_pcw", cnt_pcw - b_pcw, 32'd2);
        chk("beq_taken_alu", {29'd0, last_beq_alu}, 32'd1);
        run("beq_not", 7'b1100011, 3'b000, 1'b0, 1'b0, 3, 32'h0, 4'd0);
        chk("beq_not_pcw", cnt_pcw - b_pcw, 32'd1);
        chk("beq_not_alu", {29'd0, last_beq_alu}, 32'd1);

        run("jal", 7'b1101111, 3'b000, 1'b0, 1'b0, 4, 32'h0, 4'd0);
        chk("jal_pcw", cnt_pcw - b_pcw, 32'd2);
        chk("jal_regwrite", cnt_rw - b_rw, 32'd1);

        run("jalr", 7'b1100111, 3'b000, 1'b0, 1'b0, 5, 32'h0, 4'd0);
        chk("jalr_pcw", cnt_pcw - b_pcw, 32'd2);
        chk("jalr_pcw_rs10", cnt_pcw_rs10 - b_rs10, 32'd2);
        chk("jalr_regwrite", cnt_rw - b_rw, 32'd1);

        // sw with two FETCH stalls and one MEMWRITE stall: 7 cycles
        run("sw_stall", 7'b0100011, 3'b010, 1'b0, 1'b0, 7, 32'h23, 4'd0);
        chk("sw_stall_memwrite", cnt_mw - b_mw, 32'd2);
        chk("sw_stall_pcw", cnt_pcw - b_pcw, 32'd1);

        // illegal opcode: FETCH, DECODE, then ten cycles stuck in ILLEGAL
        run("illegal", 7'b0000000, 3'b000, 1'b0, 1'b0, 12, 32'h0, 4'd13);
        chk("illegal_flag", {31'd0, illegal}, 32'd1);
        chk("illegal_cycles", cnt_ill - b_ill, 32'd10);
        chk("illegal_pcw", cnt_pcw - b_pcw, 32'd1);
        chk("illegal_rw_mw", (cnt_rw - b_rw) + (cnt_mw - b_mw), 32'd0);
        reset = 1'b1;
        cyc(1'b1);
        reset = 1'b0;
        chk("illegal_reset_state", {28'd0, state_o}, 32'd0);
        chk("illegal_reset_flag", {31'd0, illegal}, 32'd0);

        // reset in the middle of a stalled store
        run("sw_abort", 7'b0100011, 3'b010, 1'b0, 1'b0, 4, 32'h8, 4'd5);
        chk("sw_abort_mw_before", {31'd0, MemWrite}, 32'd1);
        reset = 1'b1;
        mem_ready = 1'b0;
        #3;
        chk("sw_abort_mw_in_reset", {31'd0, MemWrite}, 32'd0);
        @(posedge clk); #1;
        chk("sw_abort_state", {28'd0, state_o}, 32'd0);
        chk("sw_abort_mw_after", {31'd0, MemWrite}, 32'd0);
        reset = 1'b0;
        cyc(1'b0);
        chk("sw_abort_mw_fetch", {31'd0, MemWrite}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
